// File: rtl/vector_sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweep controller.
package vector_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_t;

    function automatic int unsigned nv(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/resp_popcount.sv
// Combinational count of bit positions where the captured response and golden word differ.
module resp_popcount #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]         i_resp,
    input  logic [W-1:0]         i_golden,
    output logic [$clog2(W+1)-1:0] o_count
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0] w_diff;

    assign w_diff = i_resp ^ i_golden;

    always_comb begin
        o_count = '0;
        for (int i = 0; i < int'(W); i++) begin
            o_count = o_count + CW'(w_diff[i]);
        end
    end

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Drives every input vector into a small combinational DUT, captures its output bit per vector
// and compares the resulting response word against a golden word latched at start.
module vector_sweep_ctrl
    import vector_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [nv(N_IN)-1:0]   golden,
    input  logic                  dut_out,
    output logic [N_IN-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [nv(N_IN)-1:0]   resp,
    output logic                  mismatch,
    output logic [N_IN:0]         err_count
);

    localparam int unsigned NV = nv(N_IN);
    localparam int unsigned CW = $clog2(SETTLE + 1);

    state_t          r_state, w_state_d;
    logic [N_IN-1:0] r_idx, w_idx_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic [NV-1:0]   r_resp, w_resp_d;
    logic [NV-1:0]   r_golden, w_golden_d;
    logic            r_valid, w_valid_d;
    logic            r_mismatch, w_mismatch_d;
    logic [N_IN:0]   r_err, w_err_d;

    logic [NV-1:0]   w_resp_cap;
    logic [N_IN:0]   w_popcnt;
    logic            w_last_vec;

    // Response word as it will look once the current sample is written.
    always_comb begin
        w_resp_cap        = r_resp;
        w_resp_cap[r_idx] = dut_out;
    end

    assign w_last_vec = (r_idx == N_IN'(NV - 1));

    resp_popcount #(
        .W (NV)
    ) u_popcount (
        .i_resp   (w_resp_cap),
        .i_golden (r_golden),
        .o_count  (w_popcnt)
    );

    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_cnt_d      = r_cnt;
        w_resp_d     = r_resp;
        w_golden_d   = r_golden;
        w_valid_d    = r_valid;
        w_mismatch_d = r_mismatch;
        w_err_d      = r_err;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_golden_d   = golden;
                    w_resp_d     = '0;
                    w_valid_d    = 1'b0;
                    w_mismatch_d = 1'b0;
                    w_err_d      = '0;
                    w_idx_d      = '0;
                    w_cnt_d      = '0;
                    w_state_d    = StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    w_state_d = StIdle;
                end else if (r_cnt == CW'(SETTLE - 1)) begin
                    w_cnt_d   = '0;
                    w_state_d = StSample;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StSample: begin
                if (abort) begin
                    w_state_d = StIdle;
                end else begin
                    w_resp_d = w_resp_cap;
                    if (w_last_vec) begin
                        // Results are registered here so they appear alongside done.
                        w_valid_d    = 1'b1;
                        w_mismatch_d = (w_resp_cap != r_golden);
                        w_err_d      = w_popcnt;
                        w_state_d    = StDone;
                    end else begin
                        w_idx_d   = r_idx + N_IN'(1);
                        w_state_d = StSettle;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_resp     <= '0;
            r_golden   <= '0;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_cnt      <= w_cnt_d;
            r_resp     <= w_resp_d;
            r_golden   <= w_golden_d;
            r_valid    <= w_valid_d;
            r_mismatch <= w_mismatch_d;
            r_err      <= w_err_d;
        end
    end

    assign busy      = (r_state == StSettle) || (r_state == StSample);
    assign done      = (r_state == StDone);
    assign dut_in    = busy ? r_idx : '0;
    assign valid     = r_valid;
    assign resp      = r_resp;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;

endmodule

// File: doc/vector_sweep_ctrl.md
# vector_sweep_ctrl

Exhaustive-stimulus sequencer for small single-output benchmark circuits in the trojan-detection flow. On `start` it drives every input vector 0 … 2^N_IN−1 into the DUT in ascending order, waits a programmable settle time, captures the DUT output bit per vector into a response word, and compares that word against a golden response. It replaces file-driven sweep loops with a synthesizable controller that sits between the test harness and one benchmark instance.

## Interface
Parameters:
- `N_IN`, 3: DUT input width; number of vectors is `NV = 2**N_IN`.
- `SETTLE`, 1: cycles each vector is held before sampling; legal range ≥ 1.

Ports:
- `CK` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin sweep; honoured only in IDLE.
- `abort` in 1: cancel sweep in progress.
- `golden` in NV: expected response; bit k is the expected output for vector k. Sampled on accepted `start`.
- `dut_out` in 1: DUT output bit.
- `dut_in` out N_IN: vector driven to the DUT.
- `busy` out 1: high from the cycle after accepted `start` until the sweep leaves SAMPLE/SETTLE.
- `done` out 1: one-cycle pulse at sweep completion.
- `valid` out 1: `resp`/`mismatch`/`err_count` hold a complete sweep result.
- `resp` out NV: captured response; bit k = `dut_out` for vector k.
- `mismatch` out 1: `resp != golden_q`.
- `err_count` out N_IN+1: popcount of `resp ^ golden_q`.

## Operation
- Reset values: state IDLE; `dut_in`=0, `busy`=0, `done`=0, `valid`=0, `resp`=0, `mismatch`=0, `err_count`=0, vector index 0, settle counter 0, `golden_q`=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 → latch `golden_q`; clear `resp`, `valid`, `mismatch`, `err_count`; set vector index 0; go to SETTLE. `abort` is ignored in IDLE.
- SETTLE: `dut_in` = vector index. Stay for exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE: write `resp[idx]` ← `dut_out`. If idx = NV−1, go to DONE; otherwise idx+1 → SETTLE. The index never wraps within a sweep.
- DONE (one cycle): `done`=1; register `mismatch` and `err_count` from the final `resp` (including the last captured bit); `valid`←1; → IDLE.
- `abort` in SETTLE or SAMPLE: → IDLE next cycle with no `done` pulse. `valid` stays 0, `resp` keeps partial captures, and `dut_in` returns to 0. An abort during SAMPLE still does not write that bit.
- `start` while busy or in DONE: ignored. `start` and `abort` asserted together in IDLE: the start is accepted.
- `reset` in any state: returns everything to reset values next edge, overriding `start`/`abort`.
- `dut_in` is 0 in IDLE and DONE.
- Results persist in IDLE until the next accepted `start` or `reset`.

## Timing
- Accepted `start` at cycle t. Vector k is driven during cycles t+1+k(SETTLE+1) … t+(k+1)(SETTLE+1).
- Vector k is sampled in cycle t+(k+1)(SETTLE+1); `dut_out` is captured at the end of that cycle.
- `done` and `valid` rise in cycle t+NV(SETTLE+1)+1. With defaults this is t+17.
- `busy` is high in cycles t+1 … t+NV(SETTLE+1). It falls in the DONE cycle.
- Earliest back-to-back restart: `start` in the cycle after DONE.
- DUT must be combinational, or settle within SETTLE cycles. There is no dut_out synchronizer.

## Structure
- Package `vector_sweep_pkg`: `state_t` enum (IDLE, SETTLE, SAMPLE, DONE), plus a helper function `nv(n)` = 2**n.
- Sub-module `resp_popcount` (parameter W): combinational popcount of `resp ^ golden_q`, feeding the `err_count` register.
- Top level holds the FSM, settle counter (width `$clog2(SETTLE+1)`), index register and capture register.

## Test plan
- Defaults; DUT = 3-input AND; golden=8'b1000_0000; `start` at t → `dut_in` steps 0..7 every 2 cycles; `done` at t+17; `resp`=8'h80, `mismatch`=0, `err_count`=0.
- Same DUT; golden=8'b1000_0001 → `resp`=8'h80, `mismatch`=1, `err_count`=1; `valid`=1 until next `start`.
- SETTLE=3, DUT = XOR3 → each vector held 3 cycles then sampled; `done` at t+33; `resp`=8'h96.
- `abort` in the SAMPLE cycle of vector 4 → IDLE next cycle; no `done`; `valid`=0; `resp[4]` is not written; `resp[3:0]` holds captured values; `dut_in`=0.
- `start` re-asserted while busy and in the DONE cycle → ignored, with timing unchanged; `start` in the cycle after DONE → new sweep clears `valid` and `resp`.
- `reset` asserted mid-sweep (vector 5) → next cycle all outputs at reset values; subsequent `start` runs a full 8-vector sweep.
